// File: rtl/iter_multdiv.sv
// iter_multdiv: iterative signed 32-bit multiplier / divider.
//   One shift-add (multiply) or restoring shift-subtract (divide) step per
//   cycle on operand magnitudes; 32 steps, then one DONE cycle for the sign
//   fix-up. Fixed latency: a start sampled at edge E0 gives data_resultRDY
//   between E33 and E34.
// Ports:
//   clock          - rising-edge clock
//   reset          - synchronous, active-low reset
//   ctrl_MULT      - start multiply (sampled in IDLE only, wins over ctrl_DIV)
//   ctrl_DIV       - start divide (sampled in IDLE only)
//   data_operandA  - signed multiplicand / dividend, captured at start
//   data_operandB  - signed multiplier / divisor, captured at start
//   data_result    - low 32 bits of product, or quotient (toward zero)
//   data_exception - product overflow, divide by zero, or 0x80000000 / -1
//   data_resultRDY - one-cycle valid pulse
//   busy           - high while an operation is in flight
module iter_multdiv #(
  parameter int WIDTH = 32  // only 32 is supported (5-bit iteration counter)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [4:0]         count;
  logic [WIDTH-1:0]   m;        // multiplicand (MUL) or divisor (DIV) magnitude
  logic [2*WIDTH-1:0] acc;      // MUL: {partial product, multiplier}; DIV: low half = quotient/dividend
  logic [WIDTH-1:0]   rem;      // restoring-divide partial remainder
  logic               neg;      // result must be negated
  logic               is_div;
  logic               div_zero;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic               mul_ovf;
  logic [WIDTH-1:0]   done_result;
  logic               done_exc;

  always_comb begin
    a_mag = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    b_mag = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    // Shift-add: add multiplicand into upper half when multiplier LSB is set,
    // then shift the whole accumulator right with the carry entering at top.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: the 33-bit partial remainder is {rem, next dividend bit}.
    // When it is >= divisor the true difference is < 2^32, so 32 bits suffice.
    div_shift = {rem, acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, m});
    div_diff  = div_shift[WIDTH-1:0] - m;
    rem_next  = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_next  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};

    prod    = neg ? (~acc + 1'b1) : acc;
    // Product fits in signed 32 bits iff bits 63..31 are all equal.
    mul_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
    quo     = neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];

    if (is_div) begin
      done_result = div_zero ? '0 : quo;
      // A positive quotient of magnitude 2^31 only arises from 0x80000000 / -1.
      done_exc    = div_zero || (!neg && acc[WIDTH-1]);
    end else begin
      done_result = prod[WIDTH-1:0];
      done_exc    = mul_ovf;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_MULT || ctrl_DIV) begin
            count    <= '0;
            busy     <= 1'b1;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            rem      <= '0;
            div_zero <= (data_operandB == '0);
            if (ctrl_MULT) begin
              state  <= MUL;
              is_div <= 1'b0;
              m      <= a_mag;
              acc    <= {{WIDTH{1'b0}}, b_mag};
            end else begin
              state  <= DIV;
              is_div <= 1'b1;
              m      <= b_mag;
              acc    <= {{WIDTH{1'b0}}, a_mag};
            end
          end
        end
        MUL: begin
          acc   <= mul_next;
          count <= count + 5'd1;
          if (count == 5'd31) state <= DONE;
        end
        DIV: begin
          acc   <= div_next;
          rem   <= rem_next;
          count <= count + 5'd1;
          if (count == 5'd31) state <= DONE;
        end
        DONE: begin
          data_result    <= done_result;
          data_exception <= done_exc;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_multdiv.sv
module tb_iter_multdiv;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] prev_res;

  iter_multdiv #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Start an operation at the next edge (E0), scramble operands afterwards,
  // optionally pulse ctrl_DIV at edge E<pulse_at>, and check latency/result.
  task automatic run_op(input string tag, input logic mult, input logic div,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc,
                        input int pulse_at);
    int rdy_cyc  = -1;
    int busy_cnt = 0;
    ctrl_MULT     = mult;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    check({tag, " busy@E0"}, {31'b0, busy}, 32'd1);
    check({tag, " rdy@E0"}, {31'b0, data_resultRDY}, 32'd0);
    check({tag, " hold@E0"}, data_result, prev_res);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == pulse_at) ctrl_DIV = 1'b1;
      @(posedge clock); #1;
      ctrl_DIV = 1'b0;
      if (data_resultRDY) begin
        rdy_cyc = cyc;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, rdy_cyc, 32'd33);
    check({tag, " busycyc"}, busy_cnt, 32'd32);
    check({tag, " busy@rdy"}, {31'b0, busy}, 32'd0);
    check({tag, " result"}, data_result, exp_res);
    check({tag, " exc"}, {31'b0, data_exception}, {31'b0, exp_exc});
    prev_res = exp_res;
  endtask

  initial begin
    int rdy_cnt;
    reset = 1'b0; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    prev_res = '0;
    @(posedge clock); @(posedge clock); #1;
    check("rst result", data_result, 32'd0);
    check("rst exc",    {31'b0, data_exception}, 32'd0);
    check("rst rdy",    {31'b0, data_resultRDY}, 32'd0);
    check("rst busy",   {31'b0, busy}, 32'd0);
    reset = 1'b1;

    // Back-to-back: each call starts at the edge following the RDY sample.
    run_op("mul 6*7",      1, 0, 32'd6,          32'd7,          32'd42,         0, 0);
    run_op("mul -3*5",     1, 0, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1,   0, 0);
    run_op("mul 2^16sq",   1, 0, 32'h00010000,   32'h00010000,   32'h00000000,   1, 0);
    run_op("mul 0*-5",     1, 0, 32'd0,          32'hFFFFFFFB,   32'd0,          0, 0);
    run_op("div -7/2",     0, 1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   0, 0);
    run_op("div 100/-10",  0, 1, 32'd100,        32'hFFFFFFF6,   32'hFFFFFFF6,   0, 0);
    run_op("div 5/0",      0, 1, 32'd5,          32'd0,          32'd0,          1, 0);
    run_op("div min/-1",   0, 1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1, 0);
    run_op("div 0/7",      0, 1, 32'd0,          32'd7,          32'd0,          0, 0);
    run_op("div 1000/7",   0, 1, 32'd1000,       32'd7,          32'd142,        0, 0);
    run_op("both 8,2",     1, 1, 32'd8,          32'd2,          32'd16,         0, 0);
    run_op("mul 123*-4",   1, 0, 32'd123,        32'hFFFFFFFC,   32'hFFFFFE14,   0, 5);

    // Abort: start a multiply, reset at E10 while ctrl_MULT is also high.
    @(posedge clock); #1;
    ctrl_MULT = 1'b1; data_operandA = 32'd6; data_operandB = 32'd7;
    @(posedge clock); #1;  // E0
    ctrl_MULT = 1'b0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clock); #1;
    end
    reset = 1'b0; ctrl_MULT = 1'b1;
    @(posedge clock); #1;  // E10
    check("abort busy",   {31'b0, busy}, 32'd0);
    check("abort result", data_result, 32'd0);
    check("abort exc",    {31'b0, data_exception}, 32'd0);
    reset = 1'b1; ctrl_MULT = 1'b0;
    rdy_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clock); #1;
      if (data_resultRDY || busy) rdy_cnt++;
    end
    check("abort no rdy", rdy_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iter_multdiv.md
ITER_MULTDIV -- requirements
Module: iter_multdiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clock  input  1  master clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; 0 sampled at a rising edge resets the block.
REQ-004 SHALL have port ctrl_MULT  input  1  start-multiply pulse, sampled only in IDLE.
REQ-005 SHALL have port ctrl_DIV  input  1  start-divide pulse, sampled only in IDLE.
REQ-006 SHALL have port data_operandA  input  32  signed multiplicand or dividend, captured at start.
REQ-007 SHALL have port data_operandB  input  32  signed multiplier or divisor, captured at start.
REQ-008 SHALL have port data_result  output  32  signed product (low 32 bits) or quotient.
REQ-009 SHALL have port data_exception  output  1  overflow or divide-by-zero flag for the current result.
REQ-010 SHALL have port data_resultRDY  output  1  one-cycle pulse marking a valid result.
REQ-011 SHALL have port busy  output  1  high while an operation is in flight, for processor stall logic.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE, with a 5-bit iteration counter.
REQ-013 SHALL, in IDLE at a rising edge with ctrl_MULT=1, latch both operands, clear counter, and enter MUL.
REQ-014 SHALL, in IDLE at a rising edge with ctrl_DIV=1 and ctrl_MULT=0, latch operands, clear counter, and enter DIV.
REQ-015 SHALL give ctrl_MULT priority when ctrl_MULT and ctrl_DIV are both 1.
REQ-016 SHALL ignore ctrl_MULT, ctrl_DIV and operand changes outside IDLE.
REQ-017 SHALL perform one iteration per cycle on operand magnitudes in MUL and DIV:
- MUL: shift-add, 64-bit accumulator.
- DIV: restoring shift-subtract, 32-bit quotient and 33-bit remainder.
REQ-018 SHALL move from MUL or DIV to DONE at the edge on which the counter wraps from 31 to 0 (32 iterations).
REQ-019 SHALL, on entry to DONE, apply the sign correction and update data_result and data_exception.
REQ-020 SHALL assert data_resultRDY for exactly the one cycle following entry to DONE, then return to IDLE.
REQ-021 SHALL give a fixed latency: start sampled at edge E0 puts data_resultRDY=1 between edges E33 and E34, for every operand value.
REQ-022 SHALL hold data_result and data_exception stable from E33 until the next DONE entry.
REQ-023 SHALL accept a new start in the IDLE cycle immediately after DONE (back-to-back throughput of 34 cycles).
REQ-024 SHALL drive busy=1 in MUL, DIV and DONE, and busy=0 in IDLE.
REQ-025 SHALL return the low 32 bits of the true product for multiply, and set data_exception=1 iff the signed 64-bit product is outside [-2^31, 2^31-1].
REQ-026 SHALL truncate the quotient toward zero for divide and discard the remainder.
REQ-027 SHALL, for divide by zero, return data_result=0 and data_exception=1, still after the full 33-cycle latency.
REQ-028 SHALL, for 0x80000000 / -1, return data_result=0x80000000 and data_exception=1.
REQ-029 SHALL treat a zero operand as a normal case: result 0, exception 0, except for a zero divisor.

Reset
REQ-030 SHALL, on reset=0 at a rising edge, enter IDLE and clear the counter, busy, data_resultRDY, data_result and data_exception to 0.
REQ-031 SHALL, on reset during MUL, DIV or DONE, abort the operation and never emit data_resultRDY for it.
REQ-032 SHALL ignore ctrl_MULT and ctrl_DIV on any edge where reset=0.

Verification
REQ-033 SHALL cover: MULT with A=6, B=7 at E0 -> busy=1 E1..E33; RDY=1 only between E33 and E34; result=42; exception=0.
REQ-034 SHALL cover: MULT with A=-3, B=5 -> result=0xFFFFFFF1; exception=0. MULT with A=0x00010000, B=0x00010000 -> result=0; exception=1.
REQ-035 SHALL cover: DIV with A=-7, B=2 -> result=0xFFFFFFFD (-3); exception=0. DIV with A=100, B=-10 -> result=-10.
REQ-036 SHALL cover: DIV with A=5, B=0 -> RDY at E33; result=0; exception=1. DIV with A=0x80000000, B=-1 -> result=0x80000000; exception=1.
REQ-037 SHALL cover: start MULT, then drive reset=0 at E10 -> busy=0 and result=0 from E10; no RDY pulse in the next 40 cycles.
REQ-038 SHALL cover: ctrl_MULT and ctrl_DIV both 1 with A=8, B=2 -> result=16. ctrl_DIV pulsed at E5 during a MULT -> ignored; only one RDY, at E33.
